// File: rtl/mips_mem_arbiter_if.sv
// Requester and memory-side bundle of the unified-memory arbiter.
// The arbiter takes the slave view; a requester/memory model takes the master view.
interface mips_mem_arbiter_if #(
  parameter int N = 32
);
  // Grant enable
  logic         ena;

  // Instruction fetch port (read-only)
  logic         if_req;
  logic [N-1:0] if_addr;
  logic         if_ack;

  // Data load/store port
  logic         d_req;
  logic         d_wr;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wr_data;
  logic         d_ack;

  // Debug/loader port
  logic         dbg_req;
  logic         dbg_wr;
  logic [N-1:0] dbg_addr;
  logic [N-1:0] dbg_wr_data;
  logic         dbg_ack;

  // Shared response
  logic [N-1:0] rd_data;
  logic         err;
  logic [1:0]   grant_id;
  logic         busy;

  // Memory side
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wr_data;
  logic         mem_wr_ena;
  logic [N-1:0] mem_rd_data;

  modport slave (
    input  ena,
    input  if_req, if_addr,
    output if_ack,
    input  d_req, d_wr, d_addr, d_wr_data,
    output d_ack,
    input  dbg_req, dbg_wr, dbg_addr, dbg_wr_data,
    output dbg_ack,
    output rd_data, err, grant_id, busy,
    output mem_addr, mem_wr_data, mem_wr_ena,
    input  mem_rd_data
  );

  modport master (
    output ena,
    output if_req, if_addr,
    input  if_ack,
    output d_req, d_wr, d_addr, d_wr_data,
    input  d_ack,
    output dbg_req, dbg_wr, dbg_addr, dbg_wr_data,
    input  dbg_ack,
    input  rd_data, err, grant_id, busy,
    input  mem_addr, mem_wr_data, mem_wr_ena,
    output mem_rd_data
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Unified memory port arbiter for the multicycle MIPS core.
// Three requesters (IF, D, DBG) share one memory port; one transaction at a
// time is sequenced IDLE -> ISSUE -> (WAIT) -> RESP. Priority DBG > D > IF,
// with an anti-starvation override that forces IF to win after STARVE_LIMIT
// consecutive lost arbitrations.
module mips_mem_arbiter #(
  parameter int N            = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  mips_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IF   = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;
  localparam logic [1:0] G_DBG  = 2'd3;

  // Starvation counter must be able to hold STARVE_LIMIT itself.
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int CW = 3;

  state_t         state;
  state_t         state_nx;

  logic [1:0]     gid_q;
  logic           lat_wr;
  logic [N-1:0]   lat_addr;
  logic [N-1:0]   lat_wdata;
  logic [N-1:0]   rd_q;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  starve_cnt;

  logic [1:0]     win;
  logic           grant_go;
  logic           aligned;
  logic           lat_done;

  logic           if_ack_c;
  logic           d_ack_c;
  logic           dbg_ack_c;
  logic           err_c;
  logic           wr_ena_c;
  logic           busy_c;

  function automatic logic is_aligned(input logic [1:0] a);
    return (a == 2'b00);
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
    if (c == SW'(STARVE_LIMIT)) return c;
    return c + SW'(1);
  endfunction

  assign aligned  = is_aligned(lat_addr[1:0]);
  assign lat_done = (cnt == CW'(MEM_LATENCY));

  // Pick the winner among the live requests (starvation override first).
  always_comb begin
    win = G_NONE;
    if ((STARVE_LIMIT != 0) && bus.if_req && (starve_cnt == SW'(STARVE_LIMIT)))
      win = G_IF;
    else if (bus.dbg_req)
      win = G_DBG;
    else if (bus.d_req)
      win = G_D;
    else if (bus.if_req)
      win = G_IF;
  end

  assign grant_go = (state == IDLE) && bus.ena && (win != G_NONE);

  // FSM state register; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and per-state output decode.
  always_comb begin
    state_nx  = state;
    if_ack_c  = 1'b0;
    d_ack_c   = 1'b0;
    dbg_ack_c = 1'b0;
    err_c     = 1'b0;
    wr_ena_c  = 1'b0;
    busy_c    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (grant_go) state_nx = ISSUE;
      end
      ISSUE: begin
        // A misaligned write never strobes the memory.
        wr_ena_c = lat_wr & aligned;
        state_nx = lat_wr ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_done) state_nx = RESP;
      end
      RESP: begin
        if_ack_c  = (gid_q == G_IF);
        d_ack_c   = (gid_q == G_D);
        dbg_ack_c = (gid_q == G_DBG);
        err_c     = ~aligned;
        state_nx  = IDLE;
      end
    endcase
  end

  // Latch the winning request, count read latency, capture read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gid_q     <= G_NONE;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_q      <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_go) begin
            gid_q <= win;
            unique case (win)
              G_IF: begin
                lat_addr <= bus.if_addr;
                lat_wr   <= 1'b0;
              end
              G_D: begin
                lat_addr  <= bus.d_addr;
                lat_wr    <= bus.d_wr;
                lat_wdata <= bus.d_wr_data;
              end
              G_DBG: begin
                lat_addr  <= bus.dbg_addr;
                lat_wr    <= bus.dbg_wr;
                lat_wdata <= bus.dbg_wr_data;
              end
              default: ;
            endcase
          end
        end
        ISSUE: begin
          cnt <= CW'(1);
        end
        WAIT: begin
          if (lat_done) rd_q <= aligned ? bus.mem_rd_data : '0;
          else          cnt  <= cnt + CW'(1);
        end
        RESP: begin
          // Read data is only meaningful in the ack cycle.
          gid_q <= G_NONE;
          rd_q  <= '0;
        end
      endcase
    end
  end

  // Track consecutive IF losses; frozen whenever no grant happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_go) begin
      if (!bus.if_req || (win == G_IF)) starve_cnt <= '0;
      else                              starve_cnt <= sat_inc(starve_cnt);
    end
  end

  assign bus.if_ack      = if_ack_c;
  assign bus.d_ack       = d_ack_c;
  assign bus.dbg_ack     = dbg_ack_c;
  assign bus.err         = err_c;
  assign bus.busy        = busy_c;
  assign bus.grant_id    = gid_q;
  assign bus.rd_data     = rd_q;
  assign bus.mem_addr    = lat_addr;
  assign bus.mem_wr_data = lat_wdata;
  assign bus.mem_wr_ena  = wr_ena_c;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: two instances (MEM_LATENCY 1 and 3)
// share the same stimulus; `sel` picks which one is observed.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        ena;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req, d_wr;
  logic [31:0] d_addr, d_wr_data;
  logic        dbg_req, dbg_wr;
  logic [31:0] dbg_addr, dbg_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter_if #(.N(32)) b1 ();
  mips_mem_arbiter_if #(.N(32)) b3 ();

  mips_mem_arbiter #(.N(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  mips_mem_arbiter #(.N(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  // Memory contents model
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_000A;
    return (a ^ 32'h5A5A_0000) + 32'h1;
  endfunction

  assign b1.ena = ena;  assign b3.ena = ena;
  assign b1.if_req = if_req;  assign b3.if_req = if_req;
  assign b1.if_addr = if_addr;  assign b3.if_addr = if_addr;
  assign b1.d_req = d_req;  assign b3.d_req = d_req;
  assign b1.d_wr = d_wr;  assign b3.d_wr = d_wr;
  assign b1.d_addr = d_addr;  assign b3.d_addr = d_addr;
  assign b1.d_wr_data = d_wr_data;  assign b3.d_wr_data = d_wr_data;
  assign b1.dbg_req = dbg_req;  assign b3.dbg_req = dbg_req;
  assign b1.dbg_wr = dbg_wr;  assign b3.dbg_wr = dbg_wr;
  assign b1.dbg_addr = dbg_addr;  assign b3.dbg_addr = dbg_addr;
  assign b1.dbg_wr_data = dbg_wr_data;  assign b3.dbg_wr_data = dbg_wr_data;
  assign b1.mem_rd_data = memf(b1.mem_addr);
  assign b3.mem_rd_data = memf(b3.mem_addr);

  logic        o_if_ack, o_d_ack, o_dbg_ack, o_err, o_busy, o_mwe;
  logic [1:0]  o_gid;
  logic [31:0] o_rd, o_maddr, o_mwd;
  assign o_if_ack  = sel ? b3.if_ack      : b1.if_ack;
  assign o_d_ack   = sel ? b3.d_ack       : b1.d_ack;
  assign o_dbg_ack = sel ? b3.dbg_ack     : b1.dbg_ack;
  assign o_err     = sel ? b3.err         : b1.err;
  assign o_busy    = sel ? b3.busy        : b1.busy;
  assign o_mwe     = sel ? b3.mem_wr_ena  : b1.mem_wr_ena;
  assign o_gid     = sel ? b3.grant_id    : b1.grant_id;
  assign o_rd      = sel ? b3.rd_data     : b1.rd_data;
  assign o_maddr   = sel ? b3.mem_addr    : b1.mem_addr;
  assign o_mwd     = sel ? b3.mem_wr_data : b1.mem_wr_data;

  typedef struct {
    int          port;
    bit          chk_rd;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic expect_ack(input int port, input bit chk_rd, input logic [31:0] rd,
                            input logic err);
    exp_t e;
    e.port = port; e.chk_rd = chk_rd; e.rd = rd; e.err = err;
    q.push_back(e);
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? o_if_ack : (p == 2) ? o_d_ack : o_dbg_ack;
  endfunction

  task automatic drop(input int p);
    if (p == 1) if_req = 1'b0;
    else if (p == 2) d_req = 1'b0;
    else dbg_req = 1'b0;
  endtask

  // Monitor: every ack pulse is matched against the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   p;
    int   nack;
    forever begin
      @(negedge clk);
      nack = int'(o_if_ack) + int'(o_d_ack) + int'(o_dbg_ack);
      if (nack != 0) begin
        p = o_dbg_ack ? 3 : (o_d_ack ? 2 : 1);
        chk("single_ack", nack, 1);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack actual_port=%0d required=none", p);
        end else begin
          e = q.pop_front();
          chk("ack_port", p, e.port);
          chk("ack_err", o_err, e.err);
          if (e.chk_rd) chk("rd_data", o_rd, e.rd);
        end
      end
    end
  end

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_gid"}, o_gid, 0);
    chk({nm, "_acks"}, {o_if_ack, o_d_ack, o_dbg_ack}, 0);
    chk({nm, "_mwe"}, o_mwe, 0);
    chk({nm, "_maddr"}, o_maddr, 0);
    chk({nm, "_mwd"}, o_mwd, 0);
    chk({nm, "_rd_err"}, {o_rd, o_err}, 0);
  endtask

  // One isolated transaction, checking ack cycle, grant and write strobe.
  task automatic run(input int port, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int exp_cyc,
                     input logic [31:0] exp_rd, input logic exp_err);
    int cyc;
    int wecnt;
    bit seen;
    expect_ack(port, !wr, exp_rd, exp_err);
    @(posedge clk); #1;
    ena = 1'b1;
    if (port == 1) begin
      if_req = 1'b1; if_addr = addr;
    end else if (port == 2) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wr_data = wd;
    end else begin
      dbg_req = 1'b1; dbg_wr = wr; dbg_addr = addr; dbg_wr_data = wd;
    end
    cyc = 0; wecnt = 0; seen = 0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (o_mwe) wecnt++;
      chk("grant_id", o_gid, port);
      if (cyc == 1) begin
        chk("issue_maddr", o_maddr, addr);
        if (wr) chk("issue_mwd", o_mwd, wd);
      end
      if (ack_of(port)) begin
        seen = 1;
        drop(port);
      end
    end
    chk("ack_cycle", cyc, exp_cyc);
    chk("wr_strobe_cnt", wecnt, (wr && addr[1:0] == 2'b00) ? 1 : 0);
    @(negedge clk);
    chk("grant_clear", {o_gid, o_busy}, 0);
    chk("maddr_hold", o_maddr, addr);
  endtask

  int exp_port[6] = '{2, 2, 2, 2, 1, 2};
  int exp_sc[6]   = '{1, 2, 3, 4, 0, 0};

  initial begin : stim
    int n;
    int cyc;
    sel = 1'b0; ena = 1'b0;
    if_req = 0; if_addr = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wr_data = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wr_data = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    chk_outs_zero("reset");
    chk("reset_starve", u1.starve_cnt, 0);
    @(posedge clk); #1 rst = 1'b1;

    // IF read, latency 1
    run(1, 1'b0, 32'h0040_0000, 32'h0, 3, 32'h2008_000A, 1'b0);
    // D write, aligned
    run(2, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
    // D write, misaligned
    run(2, 1'b1, 32'h1001_0002, 32'hCAFE_F00D, 2, 32'h0, 1'b1);
    // IF read, misaligned: full latency, zero data, err
    run(1, 1'b0, 32'h0040_0006, 32'h0, 3, 32'h0, 1'b1);
    // D read and DBG write
    run(2, 1'b0, 32'h1001_0008, 32'h0, 3, memf(32'h1001_0008), 1'b0);
    run(3, 1'b1, 32'h3000_0010, 32'h1357_9BDF, 2, 32'h0, 1'b0);

    // Starvation: D and IF held high continuously
    for (int i = 0; i < 6; i++)
      expect_ack(exp_port[i], exp_port[i] == 1, memf(32'h0040_0010), 1'b0);
    @(posedge clk); #1;
    d_req = 1; d_wr = 1; d_addr = 32'h1001_0010; d_wr_data = 32'h0BAD_F00D;
    if_req = 1; if_addr = 32'h0040_0010;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_if_ack || o_d_ack) begin
        chk("starve_grant", o_gid, exp_port[n]);
        chk("starve_cnt", u1.starve_cnt, exp_sc[n]);
        if (o_if_ack) if_req = 1'b0;
        n++;
      end
    end
    d_req = 1'b0;
    chk("starve_acks", n, 6);

    // All three at once: DBG, then D, then IF
    expect_ack(3, 1'b0, 32'h0, 1'b0);
    expect_ack(2, 1'b1, memf(32'h1001_0020), 1'b0);
    expect_ack(1, 1'b1, memf(32'h0040_0030), 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 32'h3000_0000; dbg_wr_data = 32'h1234_5678;
    d_req = 1; d_wr = 0; d_addr = 32'h1001_0020;
    if_req = 1; if_addr = 32'h0040_0030;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (o_d_ack) chk("prio_starve_d", u1.starve_cnt, 2);
      if (o_if_ack) chk("prio_starve_if", u1.starve_cnt, 0);
      if (o_if_ack || o_d_ack || o_dbg_ack) n++;
      if (o_dbg_ack) dbg_req = 1'b0;
      if (o_d_ack) d_req = 1'b0;
      if (o_if_ack) if_req = 1'b0;
    end
    chk("prio_acks", n, 3);

    // Switch to the latency-3 instance from a clean reset
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    chk_outs_zero("reset3");
    @(posedge clk); #1 rst = 1'b1;

    // DBG read aborted by reset during WAIT
    @(posedge clk); #1;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 32'h2000_0000;
    repeat (3) @(negedge clk);
    chk("abort_pre_gid", o_gid, 3);
    chk("abort_pre_busy", o_busy, 1);
    #1 rst = 1'b0;
    #1;
    chk_outs_zero("abort");
    dbg_req = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle", o_busy, 0);
    run(1, 1'b0, 32'h0040_0000, 32'h0, 5, 32'h2008_000A, 1'b0);

    // ena low blocks new grants
    @(posedge clk); #1;
    ena = 1'b0;
    if_req = 1'b1; if_addr = 32'h0040_0020;
    repeat (5) begin
      @(negedge clk);
      chk("ena_off_busy", {o_busy, o_if_ack}, 0);
    end
    run(1, 1'b0, 32'h0040_0020, 32'h0, 5, memf(32'h0040_0020), 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
